seg_led_dynamic: RTL and testbench
==================================

Name: seg_led_dynamic

Overview:
- Parametrised multiplexed driver for an NUM_DIG-digit common-anode 7-segment display. Successor to the static single-value display path.
- Accepts a binary value on a load pulse and converts it to BCD sequentially (double-dabble).
- Scans the digits one at a time at a programmable rate, with per-digit decimal points and a global enable.
- Sits between a counter or measurement source (e.g. a time_count-driven counter) and the board's sel/seg_led pins.

Parameters:
- NUM_DIG, 6: number of digits; width of sel and point.
- DATA_W, 20: width of the binary input.
- SCAN_CNT, 50000: sys_clk cycles each digit is lit (1 ms at 50 MHz); must be ≥2.
- MAX_VAL, 999999: saturation limit; must equal 10^NUM_DIG-1 and be < 2^DATA_W.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  reset; one clock, synchronous, active-low
- data  input  DATA_W  unsigned binary value to display
- load  input  1  1-cycle strobe; samples data when idle
- point  input  NUM_DIG  decimal point per digit, 1 = lit; bit 0 = rightmost digit
- en  input  1  1 = display on, 0 = all segments and digits off
- busy  output  1  conversion in progress; load ignored while high
- sel  output  NUM_DIG  digit select, active-low, one-hot-low; bit 0 = rightmost
- seg_led  output  8  segments, active-low; [7] = dp, [6:0] = g..a

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - sel = all 1s, seg_led = 8'hFF, busy = 0.
  - Display BCD register = 0, digit index = 0, scan counter = 0, conversion FSM = IDLE.
  - Reset during a conversion aborts it; the display shows 0 after reset.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: on load=1, capture min(data, MAX_VAL) and go to SHIFT. The cycle after the load edge, busy=1.
  - SHIFT: DATA_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one, bringing in the input MSB first. After the last iteration go to DONE.
  - DONE: write the working BCD into the display register (lower NUM_DIG nibbles); go to IDLE. busy stays high in DONE.
  - busy is therefore high for exactly DATA_W+1 cycles. The new value is visible on the first scan update after DONE.
  - load while busy, including in DONE, is ignored with no queuing.
- Scan:
  - Counter runs 0..SCAN_CNT-1 continuously, independent of en.
  - At the terminal count, the digit index advances; it wraps NUM_DIG-1 → 0.
  - Outputs are registered, one-cycle latency from index/display to pins:
    - sel[idx] = 0, all other bits 1.
    - seg_led = {~point[idx], ~decode(nibble[idx])}.
  - decode: 0-9 map to standard g..a patterns; nibbles 10-15 (unreachable) map to blank.
  - en=0: sel = all 1s and seg_led = 8'hFF from the next cycle; scanning and conversion continue. en=1 resumes at the current index.
- Display register only changes in DONE. A mid-scan update is allowed; there is no frame synchronisation.

Optional Feature:
- Macro: SEG_LED_ZERO_BLANK_EN.
- Defined: any digit idx ≥1 whose nibble and all higher nibbles are 0 is blanked (seg[6:0] = 7'h7F). Its dp still follows point[idx]. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits always shown, with leading zeros.

Decomposition:
- Package seg_led_pkg:
  - 7-segment pattern constants for 0-9 and blank.
  - decode function (4-bit → 7-bit active-low).
  - Constant SEG_OFF = 8'hFF.
- One sub-module: bin2bcd_seq. It owns the IDLE/SHIFT/DONE FSM, the busy flag and the working shift registers, and outputs the BCD value plus a 1-cycle done pulse.
- The top owns the display register, scan counter, digit index and output registers.

Test Plan (bench uses SCAN_CNT=4, NUM_DIG=6, DATA_W=20):
- Release reset, en=1, no load → sel steps 111110, 111101, ... every 4 cycles; seg_led = 8'hC0 ("0") on all digits; busy = 0.
- load with data=123456 → busy high 21 cycles; then digit0 = 8'h82 ("6"), digit5 = 8'hF9 ("1").
- load data=1048575 → clamps, all digits show 8'h90 ("9"). A second load issued while busy is high → ignored; the value is unchanged.
- data=42 with macro defined → digits 2-5 = 8'hFF, digit1 = 8'h99, digit0 = 8'hA4. Without macro → digits 2-5 = 8'hC0.
- point=6'b000100, en toggled 1→0→1 → dp low only on digit2; while en=0, sel = 6'h3F and seg_led = 8'hFF; scanning resumes at the correct index.
- Assert sys_rst_n=0 mid-SHIFT → next cycle busy=0, sel all 1s, seg_led = 8'hFF; after release, all digits show "0".

Source files
------------

// File: rtl/seg_led_pkg.sv
// Shared constants for the multiplexed 7-segment driver: active-low segment patterns,
// the digit decoder and the conversion FSM state type.
package seg_led_pkg;

    // Active-low g..a patterns, bit 0 = segment a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_t;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, busy from load until the
// result is handed over in the DONE cycle (o_done).
module bin2bcd_seq
    import seg_led_pkg::*;
#(
    parameter int unsigned NUM_DIG = 6,
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned MAX_VAL = 999999
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_W-1:0]    i_data,
    input  logic                 i_load,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NUM_DIG*4-1:0] o_bcd
);

    localparam int unsigned BCD_W = NUM_DIG * 4;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    conv_state_t        r_state;
    conv_state_t        w_state_d;
    logic [DATA_W-1:0]  r_bin;
    logic [DATA_W-1:0]  w_bin_d;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_d;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_bin_d   = r_bin;
        w_bcd_d   = r_bcd;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (i_load) begin
                    w_bin_d   = (i_data > DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL) : i_data;
                    w_bcd_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                {w_bcd_d, w_bin_d} = {w_adj, r_bin} << 1;
                w_cnt_d = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_bin   <= w_bin_d;
            r_bcd   <= w_bcd_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StDone);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_led_dynamic.sv
// Multiplexed common-anode 7-segment driver with sequential BCD conversion.
// Define SEG_LED_ZERO_BLANK_EN to blank leading zero digits.
module seg_led_dynamic
    import seg_led_pkg::*;
#(
    parameter int unsigned NUM_DIG  = 6,
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned SCAN_CNT = 50000,
    parameter int unsigned MAX_VAL  = 999999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [DATA_W-1:0]  data,
    input  logic               load,
    input  logic [NUM_DIG-1:0] point,
    input  logic               en,
    output logic               busy,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg_led
);

    localparam int unsigned BCD_W = NUM_DIG * 4;
    localparam int unsigned CNT_W = $clog2(SCAN_CNT);
    localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [BCD_W-1:0]   w_bcd;
    logic               w_done;
    logic [BCD_W-1:0]   r_disp;
    logic [CNT_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_DIG-1:0] r_sel;
    logic [7:0]         r_seg;
    logic               w_last;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic               w_blank_cur;

    bin2bcd_seq #(
        .NUM_DIG (NUM_DIG),
        .DATA_W  (DATA_W),
        .MAX_VAL (MAX_VAL)
    ) u_bin2bcd (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_data  (data),
        .i_load  (load),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_nib = '0;
        w_dp  = 1'b0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_disp[4*i +: 4];
                w_dp  = point[i];
            end
        end
    end

`ifdef SEG_LED_ZERO_BLANK_EN
    logic [NUM_DIG-1:0] w_blank;
    logic               w_nz_seen;

    // Walk from the top digit down; a digit is blank while nothing above or at it is nonzero
    always_comb begin
        w_blank   = '0;
        w_nz_seen = 1'b0;
        for (int i = int'(NUM_DIG) - 1; i >= 1; i--) begin
            w_nz_seen  = w_nz_seen | (r_disp[4*i +: 4] != 4'd0);
            w_blank[i] = ~w_nz_seen;
        end
        w_blank_cur = 1'b0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_blank_cur = w_blank[i];
            end
        end
    end
`else
    assign w_blank_cur = 1'b0;
`endif

    assign w_last = (r_scan_cnt == CNT_W'(SCAN_CNT - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_disp     <= '0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_sel      <= '1;
            r_seg      <= SEG_OFF;
        end else begin
            if (w_done) begin
                r_disp <= w_bcd;
            end
            if (w_last) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_W'(NUM_DIG - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
            end
            if (en) begin
                r_sel <= ~(NUM_DIG'(1) << r_idx);
                r_seg <= {~w_dp, w_blank_cur ? SEG_BLANK : decode(w_nib)};
            end else begin
                r_sel <= '1;
                r_seg <= SEG_OFF;
            end
        end
    end

    assign sel     = r_sel;
    assign seg_led = r_seg;

endmodule

// File: tb/tb_seg_led_dynamic.sv
// Directed bench for seg_led_dynamic with SCAN_CNT=4, NUM_DIG=6, DATA_W=20.
// Honours SEG_LED_ZERO_BLANK_EN for the leading-zero expectations.
module tb_seg_led_dynamic;

    localparam int NUM_DIG = 6;
    localparam int DATA_W  = 20;

`ifdef SEG_LED_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
    localparam logic [7:0] LZ_DP = 8'h7F;
`else
    localparam logic [7:0] LZ = 8'hC0;
    localparam logic [7:0] LZ_DP = 8'h40;
`endif

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [DATA_W-1:0] data;
    logic              load;
    logic [NUM_DIG-1:0] point;
    logic              en;
    logic              busy;
    logic [NUM_DIG-1:0] sel;
    logic [7:0]        seg_led;

    int n_tests = 0;
    int n_fail  = 0;

    seg_led_dynamic #(
        .NUM_DIG  (NUM_DIG),
        .DATA_W   (DATA_W),
        .SCAN_CNT (4),
        .MAX_VAL  (999999)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .load      (load),
        .point     (point),
        .en        (en),
        .busy      (busy),
        .sel       (sel),
        .seg_led   (seg_led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_digit(input string tag, input int d, input logic [7:0] exp);
        logic [NUM_DIG-1:0] want;
        bit ok;
        want = ~(NUM_DIG'(1) << d);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge sys_clk);
            if (sel === want) ok = 1'b1;
        end
        if (!ok) check($sformatf("%s_d%0d_timeout", tag, d), 32'd0, 32'd1);
        else     check($sformatf("%s_d%0d", tag, d), {24'd0, seg_led}, {24'd0, exp});
    endtask

    // Pulse load and count cycles with busy high; optionally fire loads mid-SHIFT and in DONE
    task automatic load_value(input logic [DATA_W-1:0] v, input bit poke, output int cycles);
        @(negedge sys_clk);
        data = v;
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (poke && (cycles == 5 || cycles == 21)) begin
                data = 20'd7;
                load = 1'b1;
            end
            @(negedge sys_clk);
            load = 1'b0;
        end
        @(negedge sys_clk);
    endtask

    initial begin
        int cyc;
        logic [7:0] exp_a [NUM_DIG];
        bit ok;

        sys_rst_n = 1'b0;
        data = '0;
        load = 1'b0;
        point = '0;
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {26'd0, sel}, 32'h3F);
        check("rst_seg", {24'd0, seg_led}, 32'hFF);

        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("scan_sel0", {26'd0, sel}, 32'h3E);
        check("scan_seg0", {24'd0, seg_led}, 32'hC0);
        repeat (4) @(negedge sys_clk);
        check("scan_sel1", {26'd0, sel}, 32'h3D);
        repeat (4) @(negedge sys_clk);
        check("scan_sel2", {26'd0, sel}, 32'h3B);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check_digit("zero", 0, 8'hC0);
        for (int d = 1; d < NUM_DIG; d++) check_digit("zero", d, LZ);

        load_value(20'd123456, 1'b0, cyc);
        check("busy_len_123456", cyc, 32'd21);
        exp_a = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        for (int d = 0; d < NUM_DIG; d++) check_digit("v123456", d, exp_a[d]);

        load_value(20'd1048575, 1'b1, cyc);
        check("busy_len_clamp", cyc, 32'd21);
        repeat (3) @(negedge sys_clk);
        check("no_queue_busy", {31'd0, busy}, 32'd0);
        for (int d = 0; d < NUM_DIG; d++) check_digit("clamp", d, 8'h90);

        load_value(20'd42, 1'b0, cyc);
        check_digit("v42", 0, 8'hA4);
        check_digit("v42", 1, 8'h99);
        for (int d = 2; d < NUM_DIG; d++) check_digit("v42", d, LZ);

        point = 6'b000100;
        check_digit("dp", 2, LZ_DP);
        check_digit("dp", 0, 8'hA4);
        check_digit("dp", 1, 8'h99);

        // Align to the first cycle digit 0 is shown, then blank for 10 cycles
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge sys_clk);
            if (sel !== 6'h3E) ok = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge sys_clk);
            if (sel === 6'h3E) ok = 1'b1;
        end
        check("en_align", {31'd0, ok}, 32'd1);
        en = 1'b0;
        @(negedge sys_clk);
        check("en_off_sel", {26'd0, sel}, 32'h3F);
        check("en_off_seg", {24'd0, seg_led}, 32'hFF);
        repeat (9) @(negedge sys_clk);
        check("en_off_hold", {26'd0, sel}, 32'h3F);
        en = 1'b1;
        @(negedge sys_clk);
        check("en_resume_sel", {26'd0, sel}, 32'h3B);
        check("en_resume_seg", {24'd0, seg_led}, {24'd0, LZ_DP});

        point = '0;
        @(negedge sys_clk);
        data = 20'd123456;
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sel", {26'd0, sel}, 32'h3F);
        check("midrst_seg", {24'd0, seg_led}, 32'hFF);
        sys_rst_n = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check_digit("postrst", 0, 8'hC0);
        for (int d = 1; d < NUM_DIG; d++) check_digit("postrst", d, LZ);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
